wb_slave_pipelined_mem: RTL and testbench



---
 rtl/wb_slave_pipelined_mem_if.sv | 35 +++
 rtl/wb_slave_pipelined_mem.sv | 131 +++++++++++++
 tb/tb_wb_slave_pipelined_mem.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_pipelined_mem_if.sv
// Wishbone classic-pipelined bus bundle for wb_slave_pipelined_mem.
//
// Signals (direction given from the master's point of view):
//   cyc, stb, we     out  bus cycle, strobe, write enable
//   adr              out  word address (ADDR_WIDTH)
//   sel              out  byte-lane select (DATA_WIDTH/8)
//   dat_i            out  write data (named from the slave's side)
//   dat_o            in   read data (named from the slave's side)
//   ack, err         in   normal / error termination
//   stall            in   pipeline stall
interface wb_slave_pipelined_mem_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic                    ack;
    logic                    err;
    logic                    stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_i,
        input  dat_o, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_i,
        output dat_o, ack, err, stall
    );
endinterface

// File: rtl/wb_slave_pipelined_mem.sv
// Generic on-chip memory target for a Wishbone classic-pipelined bus.
//
// Byte-lane writes, a fixed-depth response pipeline (LATENCY cycles from accept to ack/err),
// per-request wait-state throttling (WAITCYCLES stall cycles before each accept) and an err
// termination for word addresses at or beyond MEM_DEPTH.
//
// Ports:
//   clk    in  clock, all logic on the rising edge
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of wb_slave_pipelined_mem_if (cyc/stb/we/adr/sel/dat_i in,
//          dat_o/ack/err/stall out); the interface widths must match DATA_WIDTH/ADDR_WIDTH.
//
// Parameters: DATA_WIDTH (8..64, multiple of 8), ADDR_WIDTH, MEM_DEPTH (1..2**ADDR_WIDTH),
//             WAITCYCLES (0..15), LATENCY (1..4).
//
// Optional build macro WB_SLAVE_XPROP_EN: when defined, dat_o is driven 'x outside a read ack
// to expose consumers that sample it at the wrong time; otherwise dat_o is 0 there.
module wb_slave_pipelined_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MEM_DEPTH  = 4096,
    parameter int unsigned WAITCYCLES = 0,
    parameter int unsigned LATENCY    = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    wb_slave_pipelined_mem_if.slave  bus
);
    localparam int unsigned NumLanes = DATA_WIDTH / 8;
    localparam int unsigned IdxWidth = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]  WaitInit = 4'(WAITCYCLES);

    typedef struct packed {
        logic                  vld;
        logic                  is_err;
        logic                  is_read;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [3:0] wait_cnt_q, wait_cnt_d;
    rsp_t       pipe_q [LATENCY];
    rsp_t       pipe_d [LATENCY];

    logic                valid;
    logic                accept;
    logic                in_range;
    logic [IdxWidth-1:0] mem_idx;
    rsp_t                rsp_new;
    rsp_t                rsp_out;

    assign valid     = bus.cyc & bus.stb;
    assign bus.stall = valid & (wait_cnt_q != 4'd0);
    assign accept    = valid & ~bus.stall;
    assign in_range  = 64'(bus.adr) < 64'(MEM_DEPTH);
    assign mem_idx   = bus.adr[IdxWidth-1:0];

    // Wait-state counter: reloaded on every accept, counts down only while a request waits.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (accept) begin
            wait_cnt_d = WaitInit;
        end else if (valid && (wait_cnt_q != 4'd0)) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
        end
    end

    // Read data is captured at the accept edge, so a write accepted one edge earlier is seen.
    always_comb begin
        rsp_new         = '0;
        rsp_new.vld     = accept;
        rsp_new.is_err  = ~in_range;
        rsp_new.is_read = ~bus.we;
        if (accept && !bus.we && in_range) begin
            rsp_new.data = mem_q[mem_idx];
        end

        pipe_d[0] = rsp_new;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // Dropping cyc abandons every in-flight response on this same edge.
        if (!bus.cyc) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_d[i].vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= WaitInit;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            wait_cnt_q <= wait_cnt_d;
            pipe_q     <= pipe_d;
        end
    end

    // Memory array is deliberately not reset; out-of-range requests never write.
    always_ff @(posedge clk) begin
        if (rst_n && accept && bus.we && in_range) begin
            for (int unsigned l = 0; l < NumLanes; l++) begin
                if (bus.sel[l]) begin
                    mem_q[mem_idx][8*l +: 8] <= bus.dat_i[8*l +: 8];
                end
            end
        end
    end

    assign rsp_out = pipe_q[LATENCY-1];

    // Terminations are gated by the live cyc so a response is never shown to an idle master.
    assign bus.ack = rsp_out.vld & ~rsp_out.is_err & bus.cyc;
    assign bus.err = rsp_out.vld &  rsp_out.is_err & bus.cyc;

    always_comb begin
`ifdef WB_SLAVE_XPROP_EN
        bus.dat_o = 'x;
`else
        bus.dat_o = '0;
`endif
        if (bus.ack && rsp_out.is_read) begin
            bus.dat_o = rsp_out.data;
        end
    end
endmodule

// File: tb/tb_wb_slave_pipelined_mem.sv
// Scoreboard bench for wb_slave_pipelined_mem. Three instances cover the configurations
// exercised: u_dut0 (WAITCYCLES=0, LATENCY=1), u_dut1 (WAITCYCLES=2, LATENCY=3) and
// u_dut2 (WAITCYCLES=0, LATENCY=3). The driver pushes the hand-computed response and its
// due cycle at accept time; a forked monitor pops and compares whenever ack/err appears,
// and flags responses that are missing when due or that arrive unexpectedly.
module tb_wb_slave_pipelined_mem;
    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_rsp [3];

    logic        cyc_r  [3];
    logic        stb_r  [3];
    logic        we_r   [3];
    logic [15:0] adr_r  [3];
    logic [3:0]  sel_r  [3];
    logic [31:0] wdat_r [3];
    logic        ack_v  [3];
    logic        err_v  [3];
    logic        stall_v[3];
    logic [31:0] rdat_v [3];

    exp_t exp_q [3][$];

    wb_slave_pipelined_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_wire
        assign bus[g].cyc   = cyc_r[g];
        assign bus[g].stb   = stb_r[g];
        assign bus[g].we    = we_r[g];
        assign bus[g].adr   = adr_r[g];
        assign bus[g].sel   = sel_r[g];
        assign bus[g].dat_i = wdat_r[g];
        assign ack_v[g]     = bus[g].ack;
        assign err_v[g]     = bus[g].err;
        assign stall_v[g]   = bus[g].stall;
        assign rdat_v[g]    = bus[g].dat_o;
    end

    wb_slave_pipelined_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(4096), .WAITCYCLES(0), .LATENCY(1)
    ) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus[0])
    );

    wb_slave_pipelined_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(4096), .WAITCYCLES(2), .LATENCY(3)
    ) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus[1])
    );

    wb_slave_pipelined_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(4096), .WAITCYCLES(0), .LATENCY(3)
    ) u_dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // Samples at negedge, away from the active edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ack_v[d] === 1'b1 || err_v[d] === 1'b1) begin
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("spurious_rsp_dut%0d", d), {ack_v[d], err_v[d]}, 64'd0);
                    end else begin
                        e = exp_q[d].pop_front();
                        check($sformatf("rsp_kind_dut%0d", d), {ack_v[d], err_v[d]},
                              {~e.is_err, e.is_err});
                        check($sformatf("rsp_data_dut%0d", d), rdat_v[d], e.data);
                        check($sformatf("rsp_cycle_dut%0d", d), cycle, e.due);
                        last_rsp[d] = cycle;
                    end
                end else if (exp_q[d].size() != 0 && int'(exp_q[d][0].due) <= cycle) begin
                    e = exp_q[d].pop_front();
                    check($sformatf("missing_rsp_dut%0d", d), {ack_v[d], err_v[d]},
                          {~e.is_err, e.is_err});
                end
            end
        end
    endtask

    // Present one request, wait for it to be accepted, record the expected response.
    task automatic req(input int d, input logic w, input logic [15:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] e_data);
        int   stalls = 0;
        logic done = 1'b0;
        exp_t e;
        stb_r[d]  = 1'b1;
        we_r[d]   = w;
        adr_r[d]  = a;
        sel_r[d]  = s;
        wdat_r[d] = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stall_v[d] === 1'b1) begin
                stalls++;
            end else begin
                e.is_err = e_err;
                e.data   = e_data;
                e.due    = 32'(cycle + lat_of(d));
                exp_q[d].push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("accepted_dut%0d_adr%0h", d, a), done, 1);
        check($sformatf("stall_cycles_dut%0d_adr%0h", d, a), stalls, wait_of(d));
        stb_r[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 40 && exp_q[d].size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check($sformatf("drain_dut%0d", d), exp_q[d].size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int d = 0; d < 3; d++) begin
            cyc_r[d] = 1'b0; stb_r[d] = 1'b0; we_r[d] = 1'b0;
            adr_r[d] = '0;   sel_r[d] = '0;   wdat_r[d] = '0;
            last_rsp[d] = 0;
        end
        fork
            monitor();
        join_none

        idle(3);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ack_err_dut%0d", d), {ack_v[d], err_v[d]}, 0);
            check($sformatf("reset_stall_dut%0d", d), stall_v[d], 0);
            check($sformatf("reset_dat_o_dut%0d", d), rdat_v[d], 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) cyc_r[d] = 1'b1;
        idle(1);

        // Write then read-after-write on consecutive cycles.
        req(0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
        req(0, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF);
        drain(0);

        // Byte lanes, including a sel=0 no-op write.
        req(0, 1'b1, 16'h0020, 4'hF, 32'h11223344, 1'b0, 32'h0);
        req(0, 1'b1, 16'h0020, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0);
        req(0, 1'b0, 16'h0020, 4'hF, 32'h0, 1'b0, 32'h11BB33DD);
        req(0, 1'b1, 16'h0020, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0);
        req(0, 1'b0, 16'h0020, 4'hF, 32'h0, 1'b0, 32'h11BB33DD);
        drain(0);

        // Out-of-range: err, no write (0x1000 would alias word 0 if truncated).
        req(0, 1'b1, 16'h0000, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
        req(0, 1'b0, 16'h1000, 4'hF, 32'h0, 1'b1, 32'h0);
        req(0, 1'b1, 16'h1000, 4'hF, 32'h12345678, 1'b1, 32'h0);
        req(0, 1'b0, 16'h0000, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D);
        drain(0);

        // Wait states: 2 stalls per request, LATENCY=3, 4 back-to-back reads in 15 cycles.
        for (int k = 1; k <= 4; k++) begin
            req(1, 1'b1, 16'(k), 4'hF, 32'h01010101 * 32'(k), 1'b0, 32'h0);
        end
        drain(1);
        t0 = cycle;
        for (int k = 1; k <= 4; k++) begin
            req(1, 1'b0, 16'(k), 4'hF, 32'h0, 1'b0, 32'h01010101 * 32'(k));
        end
        drain(1);
        check("b2b_read_cycles", last_rsp[1] + 1 - t0, 15);

        // cyc drop with three responses in flight flushes them; the write stays committed.
        req(2, 1'b1, 16'h0005, 4'hF, 32'h55AA55AA, 1'b0, 32'h0);
        drain(2);
        req(2, 1'b1, 16'h0006, 4'hF, 32'h66666666, 1'b0, 32'h0);
        req(2, 1'b0, 16'h0005, 4'hF, 32'h0, 1'b0, 32'h55AA55AA);
        req(2, 1'b0, 16'h0005, 4'hF, 32'h0, 1'b0, 32'h55AA55AA);
        cyc_r[2] = 1'b0;
        exp_q[2].delete();
        idle(1);
        cyc_r[2] = 1'b1;
        idle(6);
        req(2, 1'b0, 16'h0006, 4'hF, 32'h0, 1'b0, 32'h66666666);
        req(2, 1'b0, 16'h0005, 4'hF, 32'h0, 1'b0, 32'h55AA55AA);
        drain(2);

        // One-cycle reset with two reads in flight: no responses, memory retained.
        req(2, 1'b1, 16'h0007, 4'hF, 32'h77777777, 1'b0, 32'h0);
        drain(2);
        req(2, 1'b0, 16'h0007, 4'hF, 32'h0, 1'b0, 32'h77777777);
        req(2, 1'b0, 16'h0007, 4'hF, 32'h0, 1'b0, 32'h77777777);
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) exp_q[d].delete();
        idle(1);
        rst_n = 1'b1;
        idle(6);
        req(2, 1'b0, 16'h0007, 4'hF, 32'h0, 1'b0, 32'h77777777);
        req(0, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF);
        for (int d = 0; d < 3; d++) drain(d);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
